// File: rtl/axi_mem_init_master.sv
// axi_mem_init_master: AXI write master that preloads a memory image at run time.
// Walks NUM_ENTRIES {addr, word} records from INIT_TABLE and issues one INCR burst
// per record, least significant beat first. The table image is passed in as the
// INIT_TABLE parameter; the build flow converts the hex image into it.
// Optional feature: define INIT_READBACK_EN to read every record back and count
// records whose data or rresp does not match (mismatch_cnt).
module axi_mem_init_master #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int ID_W_WIDTH  = 5,
    parameter int AW_ID       = 0,
    parameter int BEATS       = 4,
    parameter int NUM_ENTRIES = 9,
    parameter int AUTO_START  = 1,
    parameter logic [NUM_ENTRIES*(ADDR_WIDTH+BEATS*DATA_WIDTH)-1:0] INIT_TABLE = {
        16'hA020, 32'h1, 16'hA01C, 32'h1, 16'hA018, 32'h1,
        16'hA014, 32'h1, 16'hA010, 32'h2, 16'hA00C, 32'h1,
        16'hA008, 32'h1, 16'hA004, 32'h1, 16'hA000, 32'h1}
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] err_cnt,
    output logic [ID_W_WIDTH-1:0]            awid,
    output logic [ADDR_WIDTH-1:0]            awaddr,
    output logic [7:0]                       awlen,
    output logic [2:0]                       awsize,
    output logic [1:0]                       awburst,
    output logic                             awvalid,
    input  logic                             awready,
    output logic [DATA_WIDTH-1:0]            wdata,
    output logic [DATA_WIDTH/8-1:0]          wstrb,
    output logic                             wlast,
    output logic                             wvalid,
    input  logic                             wready,
    input  logic [ID_W_WIDTH-1:0]            bid,
    input  logic [1:0]                       bresp,
    input  logic                             bvalid,
`ifdef INIT_READBACK_EN
    output logic [ID_W_WIDTH-1:0]            arid,
    output logic [ADDR_WIDTH-1:0]            araddr,
    output logic [7:0]                       arlen,
    output logic [2:0]                       arsize,
    output logic [1:0]                       arburst,
    output logic                             arvalid,
    input  logic                             arready,
    input  logic [ID_W_WIDTH-1:0]            rid,
    input  logic [DATA_WIDTH-1:0]            rdata,
    input  logic [1:0]                       rresp,
    input  logic                             rlast,
    input  logic                             rvalid,
    output logic                             rready,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] mismatch_cnt,
`endif
    output logic                             bready
);

    localparam int WORD_W = BEATS * DATA_WIDTH;
    localparam int REC_W  = ADDR_WIDTH + WORD_W;
    localparam int CNT_W  = $clog2(NUM_ENTRIES + 1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  END_ENTRY = CNT_W'(NUM_ENTRIES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
`ifdef INIT_READBACK_EN
    localparam logic [2:0] S_RA   = 3'd6;
    localparam logic [2:0] S_R    = 3'd7;
`endif

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      entry_q, entry_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CNT_W-1:0]      err_q, err_d;
    logic [REC_W-1:0]      rec;
    logic [ADDR_WIDTH-1:0] rec_addr;
    logic [WORD_W-1:0]     rec_word;
    logic [DATA_WIDTH-1:0] beat_data;
`ifdef INIT_READBACK_EN
    logic [CNT_W-1:0]      mm_q, mm_d;
    logic                  flag_q, flag_d;
`endif

    // Select the current record; out-of-range entries (DONE) fall back to record 0.
    always_comb begin
        rec = INIT_TABLE[0 +: REC_W];
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entry_q == CNT_W'(i)) rec = INIT_TABLE[i*REC_W +: REC_W];
        end
    end

    assign rec_addr  = rec[REC_W-1 -: ADDR_WIDTH];
    assign rec_word  = rec[WORD_W-1:0];
    assign beat_data = rec_word[beat_q*DATA_WIDTH +: DATA_WIDTH];

    // All bus outputs decode straight from registered state so they stay stable under stalls
    // and drop in the same cycle reset asserts.
    assign awid    = ID_W_WIDTH'(AW_ID);
    assign awaddr  = rec_addr;
    assign awlen   = 8'(BEATS - 1);
    assign awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign awburst = 2'b01;
    assign awvalid = (state_q == S_AW);
    assign wdata   = beat_data;
    assign wstrb   = '1;
    assign wvalid  = (state_q == S_W);
    assign wlast   = (state_q == S_W) && (beat_q == LAST_BEAT);
    assign bready  = (state_q == S_B);
    assign done    = (state_q == S_DONE);
    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign err_cnt = err_q;

`ifdef INIT_READBACK_EN
    assign arid         = ID_W_WIDTH'(AW_ID);
    assign araddr       = rec_addr;
    assign arlen        = 8'(BEATS - 1);
    assign arsize       = 3'($clog2(DATA_WIDTH / 8));
    assign arburst      = 2'b01;
    assign arvalid      = (state_q == S_RA);
    assign rready       = (state_q == S_R);
    assign mismatch_cnt = mm_q;

    logic unused_inputs;
    assign unused_inputs = ^{1'b0, bid, rid};
`else
    logic unused_inputs;
    assign unused_inputs = ^{1'b0, bid};
`endif

    // Table walk: one burst outstanding, entry advances only in NEXT.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        beat_d  = beat_q;
        err_d   = err_q;
`ifdef INIT_READBACK_EN
        mm_d    = mm_q;
        flag_d  = flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((AUTO_START != 0) || start) begin
                    state_d = S_AW;
                    entry_d = '0;
                    err_d   = '0;
`ifdef INIT_READBACK_EN
                    mm_d    = '0;
`endif
                end
            end
            S_AW: begin
                if (awready) begin
                    state_d = S_W;
                    beat_d  = '0;
                end
            end
            S_W: begin
                if (wready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    if (bresp != 2'b00) err_d = err_q + 1'b1;
`ifdef INIT_READBACK_EN
                    state_d = S_RA;
`else
                    state_d = S_NEXT;
`endif
                end
            end
            S_NEXT: begin
                entry_d = entry_q + 1'b1;
                state_d = (entry_d == END_ENTRY) ? S_DONE : S_AW;
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_AW;
                    entry_d = '0;
                    err_d   = '0;
`ifdef INIT_READBACK_EN
                    mm_d    = '0;
`endif
                end
            end
`ifdef INIT_READBACK_EN
            S_RA: begin
                if (arready) begin
                    state_d = S_R;
                    beat_d  = '0;
                    flag_d  = 1'b0;
                end
            end
            S_R: begin
                if (rvalid) begin
                    beat_d = beat_q + 1'b1;
                    if ((rdata != beat_data) || (rresp != 2'b00)) flag_d = 1'b1;
                    if (rlast) begin
                        if (flag_d) mm_d = mm_q + 1'b1;
                        state_d = S_NEXT;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            entry_q <= '0;
            beat_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

`ifdef INIT_READBACK_EN
    // Readback mismatch bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_q   <= '0;
            flag_q <= 1'b0;
        end else begin
            mm_q   <= mm_d;
            flag_q <= flag_d;
        end
    end
`endif

endmodule

// File: tb/tb_axi_mem_init_master.sv
// Directed bench for axi_mem_init_master with a small AXI RAM slave model.
module tb_axi_mem_init_master;

    localparam logic [9*48-1:0] TAB = {
        16'hA020, 32'h1, 16'hA01C, 32'h1, 16'hA018, 32'h1,
        16'hA014, 32'h1, 16'hA010, 32'h2, 16'hA00C, 32'h1,
        16'hA008, 32'h1, 16'hA004, 32'h1, 16'hA000, 32'h1};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done;
    logic [3:0]  err_cnt;
    logic [4:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [7:0]  wdata;
    logic [0:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [4:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
`ifdef INIT_READBACK_EN
    logic [4:0]  arid, rid;
    logic [15:0] araddr;
    logic [7:0]  arlen, rdata;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  mismatch_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // slave model state
    logic [7:0]  mem [0:65535];
    logic        stall = 1'b0;
    logic        mem_clr = 1'b0;
    logic        mon_en = 1'b0;
    logic [15:0] err_mask = 16'h0;
    logic [15:0] wr_addr = 16'h0;
    logic [7:0]  wr_beat = 8'h0;
    logic        b_pend = 1'b0;
    logic [15:0] rec_off;

    assign bid = 5'd0;
    assign rec_off = (wr_addr - 16'hA000) >> 2;

    always #5 clk = ~clk;

    axi_mem_init_master #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .ID_W_WIDTH(5), .AW_ID(0),
        .BEATS(4), .NUM_ENTRIES(9), .AUTO_START(1), .INIT_TABLE(TAB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err_cnt(err_cnt),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid),
`ifdef INIT_READBACK_EN
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready), .mismatch_cnt(mismatch_cnt),
`endif
        .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // AXI write slave: random readies when stall is set, bvalid held until bready.
    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 64; i++) mem[16'hA000 + i] <= 8'hEE;
        if (rst) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            b_pend  <= 1'b0;
            wr_beat <= 8'h0;
        end else begin
            awready <= !stall || ($urandom_range(0, 1) == 1);
            wready  <= !stall || ($urandom_range(0, 1) == 1);
            if (awvalid && awready) begin
                wr_addr <= awaddr;
                wr_beat <= 8'h0;
            end
            if (wvalid && wready) begin
                mem[wr_addr + {8'h0, wr_beat}] <= wdata;
                wr_beat <= wr_beat + 8'h1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end else if (!bvalid && (b_pend || (wvalid && wready && wlast)) &&
                         (!stall || ($urandom_range(0, 1) == 1))) begin
                bvalid <= 1'b1;
                bresp  <= err_mask[rec_off[3:0]] ? 2'b10 : 2'b00;
                b_pend <= 1'b0;
            end else if (wvalid && wready && wlast) begin
                b_pend <= 1'b1;
            end
        end
    end

`ifdef INIT_READBACK_EN
    logic [15:0] rd_addr = 16'h0;
    logic [7:0]  rd_beat = 8'h0;
    assign rid   = 5'd0;
    assign rresp = 2'b00;
    assign rlast = (rd_beat == 8'd3);
    assign rdata = mem[rd_addr + {8'h0, rd_beat}] ^
                   (((rd_addr == 16'hA01C) && (rd_beat == 8'd1)) ? 8'hFF : 8'h00);
    // Read slave: corrupts byte 1 of record 7 on the way back.
    always @(posedge clk) begin
        if (rst) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            arready <= 1'b1;
            if (arvalid && arready) begin
                rd_addr <= araddr;
                rd_beat <= 8'h0;
                rvalid  <= 1'b1;
            end else if (rvalid && rready) begin
                if (rlast) rvalid <= 1'b0;
                else rd_beat <= rd_beat + 8'h1;
            end
        end
    end
`endif

    // AXI stability monitor: a stalled valid must keep its payload until accepted.
    logic        aw_wait = 1'b0, w_wait = 1'b0, wl_prev = 1'b0;
    logic [15:0] aw_prev = 16'h0;
    logic [7:0]  w_prev = 8'h0;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (aw_wait) chk("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev});
            if (w_wait)  chk("w_hold", {wvalid, wlast, wdata}, {1'b1, wl_prev, w_prev});
            aw_wait <= awvalid && !awready;
            aw_prev <= awaddr;
            w_wait  <= wvalid && !wready;
            w_prev  <= wdata;
            wl_prev <= wlast;
        end else begin
            aw_wait <= 1'b0;
            w_wait  <= 1'b0;
        end
    end

    task automatic wait_done(input int budget, input int pulse_at, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            start = (pulse_at != 0) && (n == pulse_at);
        end
        start = 1'b0;
        chk("done_in_budget", {63'h0, done}, 64'h1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_done_clr", {63'h0, done}, 64'h0);
        chk("start_busy", {63'h0, busy}, 64'h1);
        chk("start_err_clr", {60'h0, err_cnt}, 64'h0);
        chk("start_entry0", {47'h0, awvalid, awaddr}, {47'h0, 1'b1, 16'hA000});
`ifdef INIT_READBACK_EN
        chk("start_mm_clr", {60'h0, mismatch_cnt}, 64'h0);
`endif
    endtask

    task automatic chk_mem();
        for (int k = 0; k < 9; k++) begin
            logic [15:0] a;
            a = 16'hA000 + 16'(4 * k);
            chk($sformatf("mem%0d", k), {32'h0, mem[a+3], mem[a+2], mem[a+1], mem[a]},
                (k == 4) ? 64'h2 : 64'h1);
        end
    endtask

    initial begin
        int n;
        int t;
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_valids", {61'h0, awvalid, wvalid, bready}, 64'h0);
        chk("rst_err", {60'h0, err_cnt}, 64'h0);
        chk("const_fields", {45'h0, awid, awlen, awsize, awburst, wstrb},
            {45'h0, 5'd0, 8'd3, 3'd0, 2'b01, 1'b1});
        // run A: auto start, zero-wait slave
        rst = 1'b0;
        wait_done(200, 0, n);
`ifndef INIT_READBACK_EN
        chk("runA_cycles", 64'(n), 64'd64);
`else
        chk("runA_mismatch", {60'h0, mismatch_cnt}, 64'h1);
`endif
        chk("runA_busy", {63'h0, busy}, 64'h0);
        chk("runA_err", {60'h0, err_cnt}, 64'h0);
        chk_mem();
        // run B: random stalls, memory refilled from scratch
        @(negedge clk);
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
        stall  = 1'b1;
        mon_en = 1'b1;
        pulse_start();
        wait_done(3000, 0, n);
        mon_en = 1'b0;
        stall  = 1'b0;
        chk("runB_err", {60'h0, err_cnt}, 64'h0);
        chk_mem();
        // run C: SLVERR on records 2 and 5
        err_mask = 16'h0024;
        pulse_start();
        wait_done(200, 0, n);
`ifndef INIT_READBACK_EN
        chk("runC_cycles", 64'(n), 64'd63);
`endif
        chk("runC_err", {60'h0, err_cnt}, 64'h2);
        // run D: start while busy in record 3 must be ignored
        err_mask = 16'h0;
        pulse_start();
        wait_done(200, 24, n);
`ifndef INIT_READBACK_EN
        chk("runD_cycles", 64'(n), 64'd63);
`endif
        chk("runD_err", {60'h0, err_cnt}, 64'h0);
        // run E: reset during W beat 2 of record 4
        pulse_start();
        t = 0;
        while (!(wr_addr == 16'hA010 && wr_beat == 8'd2 && wvalid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("runE_reach_beat2", {63'h0, (t < 200)}, 64'h1);
        rst = 1'b1;
        #1;
        chk("runE_rst_wvalid", {63'h0, wvalid}, 64'h0);
        chk("runE_rst_busy", {63'h0, busy}, 64'h0);
        chk("runE_rst_awvalid", {63'h0, awvalid}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("runE_restart0", {47'h0, awvalid, awaddr}, {47'h0, 1'b1, 16'hA000});
        wait_done(200, 0, n);
`ifndef INIT_READBACK_EN
        chk("runE_cycles", 64'(n), 64'd63);
`endif
        chk("runE_err", {60'h0, err_cnt}, 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
